// File: rtl/scr_link_ctrl.sv
// Receive-side link controller for the x^58+x^39+1 descrambler: sequences its reset/bypass,
// waits out the fill, then tracks lock on the incrementing-counter training pattern.
//
// state  | meaning
// IDLE   | disabled, descrambler held in reset
// FLUSH  | descrambler held in reset for two cycles, bypass latched
// WARMUP | descrambler running, output ignored until its state register is full
// SEARCH | looking for LOCK_COUNT consecutive counter increments
// LOCKED | link good; mismatches counted, UNLOCK_COUNT in a row drops lock
module scr_link_ctrl #(
  parameter int WORDWIDTH    = 32,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 bypass,
  input  logic                 clrErr,
  input  logic [WORDWIDTH-1:0] dscrData,
  output logic                 dscrReset,
  output logic                 dscrBypass,
  output logic                 locked,
  output logic [1:0]           state,
  output logic [15:0]          errCount
);

  // Encoding chosen so every output is a plain flop bit: [2]=locked, [1]=descrambler out of reset.
  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] FLUSH  = 3'b001;
  localparam logic [2:0] WARMUP = 3'b010;
  localparam logic [2:0] SEARCH = 3'b011;
  localparam logic [2:0] LOCKED = 3'b111;

  localparam int WARM = (58 + WORDWIDTH - 1) / WORDWIDTH + 1;
  localparam logic [3:0] WARM_LOAD = 4'(WARM - 1);
  localparam logic [7:0] MATCH_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] BAD_LAST = 8'(UNLOCK_COUNT - 1);
  localparam logic [WORDWIDTH-1:0] WORD_ONE = {{(WORDWIDTH-1){1'b0}}, 1'b1};

  logic [2:0]           cur_st, nxt_st;
  logic                 flush_cnt, flush_nxt;
  logic [3:0]           warm_cnt, warm_nxt;
  logic [7:0]           match_cnt, match_nxt;
  logic [7:0]           bad_cnt, bad_nxt;
  logic                 search_first, first_nxt;
  logic [WORDWIDTH-1:0] prev, prev_nxt;
  logic                 byp_q, byp_nxt;
  logic [15:0]          err_q;
  logic                 word_ok;
  logic                 err_inc;

  assign word_ok = (dscrData == (prev + WORD_ONE));
  assign err_inc = (cur_st == LOCKED) && !word_ok;

  always_comb begin
    nxt_st    = cur_st;
    flush_nxt = flush_cnt;
    warm_nxt  = warm_cnt;
    match_nxt = match_cnt;
    bad_nxt   = bad_cnt;
    first_nxt = search_first;
    prev_nxt  = prev;
    byp_nxt   = byp_q;
    if (!enable) begin
      nxt_st    = IDLE;
      flush_nxt = 1'b0;
      warm_nxt  = '0;
      match_nxt = '0;
      bad_nxt   = '0;
      first_nxt = 1'b0;
    end else if ((cur_st != IDLE) && (bypass != byp_q)) begin
      // Bypass only moves on the same edge that pulls the descrambler into reset.
      nxt_st    = FLUSH;
      byp_nxt   = bypass;
      flush_nxt = 1'b1;
      warm_nxt  = '0;
      match_nxt = '0;
      bad_nxt   = '0;
      first_nxt = 1'b0;
    end else begin
      case (cur_st)
        IDLE: begin
          nxt_st    = FLUSH;
          byp_nxt   = bypass;
          flush_nxt = 1'b1;
        end
        FLUSH: begin
          if (flush_cnt == 1'b0) begin
            nxt_st   = WARMUP;
            warm_nxt = WARM_LOAD;
          end else begin
            flush_nxt = 1'b0;
          end
        end
        WARMUP: begin
          if (warm_cnt == 4'd0) begin
            nxt_st    = SEARCH;
            first_nxt = 1'b1;
            match_nxt = '0;
          end else begin
            warm_nxt = warm_cnt - 4'd1;
          end
        end
        SEARCH: begin
          prev_nxt = dscrData;
          if (search_first) begin
            first_nxt = 1'b0;
          end else if (word_ok) begin
            if (match_cnt == MATCH_LAST) begin
              nxt_st    = LOCKED;
              match_nxt = '0;
              bad_nxt   = '0;
            end else begin
              match_nxt = match_cnt + 8'd1;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          prev_nxt = dscrData;
          if (word_ok) begin
            bad_nxt = '0;
          end else if (bad_cnt == BAD_LAST) begin
            nxt_st    = FLUSH;
            flush_nxt = 1'b1;
            bad_nxt   = '0;
          end else begin
            bad_nxt = bad_cnt + 8'd1;
          end
        end
        default: nxt_st = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_st       <= IDLE;
      flush_cnt    <= 1'b0;
      warm_cnt     <= '0;
      match_cnt    <= '0;
      bad_cnt      <= '0;
      search_first <= 1'b0;
      prev         <= '0;
      byp_q        <= 1'b0;
    end else begin
      cur_st       <= nxt_st;
      flush_cnt    <= flush_nxt;
      warm_cnt     <= warm_nxt;
      match_cnt    <= match_nxt;
      bad_cnt      <= bad_nxt;
      search_first <= first_nxt;
      prev         <= prev_nxt;
      byp_q        <= byp_nxt;
    end
  end

  // A clear wins over a coincident increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= '0;
    end else if (clrErr) begin
      err_q <= '0;
    end else if (err_inc && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign state      = cur_st[1:0];
  assign locked     = cur_st[2];
  assign dscrReset  = cur_st[1];
  assign dscrBypass = byp_q;
  assign errCount   = err_q;

endmodule

// File: tb/tb_scr_link_ctrl.sv
// Bench for scr_link_ctrl: a 32-bit instance for sequencing/lock/bypass/reset and an 8-bit
// instance (long unlock window) for wrap, late lock and errCount saturation/clear.
module tb_scr_link_ctrl;

  typedef struct {
    int          cyc;
    bit          w8;
    logic [20:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst32 = 1'b0, rst8 = 1'b0;
  logic        enable32 = 1'b0, enable8 = 1'b0;
  logic        bypass32 = 1'b0, bypass8 = 1'b0;
  logic        clr32 = 1'b0, clr8 = 1'b0;
  logic [31:0] data32 = '0;
  logic [7:0]  data8 = '0;
  logic        rs32, byp32, lk32, rs8, byp8, lk8;
  logic [1:0]  st32, st8;
  logic [15:0] err32, err8;
  logic [20:0] obs32, obs8;

  logic [31:0] cnt32 = 32'h1000_0000;
  logic [7:0]  cnt8 = 8'h40;
  int          bad32 = 0, bad8 = 0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  scr_link_ctrl #(.WORDWIDTH(32), .LOCK_COUNT(16), .UNLOCK_COUNT(4)) u_dut32 (
    .clk(clk), .reset(rst32), .enable(enable32), .bypass(bypass32), .clrErr(clr32),
    .dscrData(data32), .dscrReset(rs32), .dscrBypass(byp32), .locked(lk32),
    .state(st32), .errCount(err32)
  );

  scr_link_ctrl #(.WORDWIDTH(8), .LOCK_COUNT(16), .UNLOCK_COUNT(255)) u_dut8 (
    .clk(clk), .reset(rst8), .enable(enable8), .bypass(bypass8), .clrErr(clr8),
    .dscrData(data8), .dscrReset(rs8), .dscrBypass(byp8), .locked(lk8),
    .state(st8), .errCount(err8)
  );

  assign obs32 = {st32, lk32, rs32, byp32, err32};
  assign obs8  = {st8, lk8, rs8, byp8, err8};

  // Counter streams; a corrupted word is the bitwise inverse, which can never continue the count.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    data32 = (bad32 > 0) ? ~cnt32 : cnt32;
    data8  = (bad8 > 0) ? ~cnt8 : cnt8;
    if (bad32 > 0) bad32--;
    if (bad8 > 0) bad8--;
    cnt32++;
    cnt8++;
  endtask

  function automatic void push(int c, bit w8, logic [1:0] s, logic l, logic r, logic b,
                               logic [15:0] e, string n);
    exp_t x;
    x.cyc  = c;
    x.w8   = w8;
    x.exp  = {s, l, r, b, e};
    x.name = n;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (obs32 !== 21'd0) begin
      errors++;
      $display("FAIL reset32 got=%h exp=%h", obs32, 21'd0);
    end
    checks++;
    if (obs8 !== 21'd0) begin
      errors++;
      $display("FAIL reset8 got=%h exp=%h", obs8, 21'd0);
    end
    rst32 = 1'b1;
    tick();
  endtask

  task automatic test_lock();
    exp_t e;
    logic [20:0] act;
    int e0;
    enable32 = 1'b1;
    e0 = cyc + 1;
    push(e0,      0, 2'd1, 0, 0, 0, 16'd0, "flush_e0");
    push(e0 + 1,  0, 2'd1, 0, 0, 0, 16'd0, "flush_e1");
    push(e0 + 2,  0, 2'd2, 0, 1, 0, 16'd0, "warmup_e2");
    push(e0 + 4,  0, 2'd2, 0, 1, 0, 16'd0, "warmup_e4");
    push(e0 + 5,  0, 2'd3, 0, 1, 0, 16'd0, "search_e5");
    push(e0 + 21, 0, 2'd3, 0, 1, 0, 16'd0, "prelock_e21");
    push(e0 + 22, 0, 2'd3, 1, 1, 0, 16'd0, "lock_e22");
    push(e0 + 1022, 0, 2'd3, 1, 1, 0, 16'd0, "clean_1000");
    repeat (1022) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  // A bad word also breaks the compare of the following good word, so n corrupted words
  // give n+1 consecutive mismatches.
  task automatic test_errors();
    exp_t e;
    logic [20:0] act;
    int t;
    t = cyc;
    bad32 = 2;
    push(t + 1, 0, 2'd3, 1, 1, 0, 16'd0, "err_pre");
    push(t + 3, 0, 2'd3, 1, 1, 0, 16'd2, "err_two");
    push(t + 4, 0, 2'd3, 1, 1, 0, 16'd3, "err_three_held");
    push(t + 8, 0, 2'd3, 1, 1, 0, 16'd3, "err_three_after");
    repeat (8) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
    t = cyc;
    bad32 = 3;
    push(t + 4,  0, 2'd3, 1, 1, 0, 16'd6, "unlock_pre");
    push(t + 5,  0, 2'd1, 0, 0, 0, 16'd7, "unlock_flush");
    push(t + 7,  0, 2'd2, 0, 1, 0, 16'd7, "relock_warmup");
    push(t + 26, 0, 2'd3, 0, 1, 0, 16'd7, "relock_pre");
    push(t + 27, 0, 2'd3, 1, 1, 0, 16'd7, "relock_e22");
    for (int i = 0; i < 27; i++) begin
      tick();
      // While flushing, move the stream close to the 32-bit wrap.
      if (i == 4) cnt32 = 32'hFFFF_FFDE;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [20:0] act;
    int n;
    n = 0;
    while (cnt32 != 32'h0000_0003 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wrap32_timeout got=%h exp=%h", cnt32, 32'h3);
    end else begin
      push(cyc + 1, 0, 2'd3, 1, 1, 0, 16'd7, "wrap32");
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [20:0] act;
    int t;
    t = cyc;
    bypass32 = 1'b1;
    push(t + 1,  0, 2'd1, 0, 0, 1, 16'd7, "byp_flush");
    push(t + 2,  0, 2'd1, 0, 0, 1, 16'd7, "byp_flush2");
    push(t + 3,  0, 2'd2, 0, 1, 1, 16'd7, "byp_warmup");
    push(t + 22, 0, 2'd3, 0, 1, 1, 16'd7, "byp_prelock");
    push(t + 23, 0, 2'd3, 1, 1, 1, 16'd7, "byp_relock");
    repeat (23) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t e;
    logic [20:0] act;
    int t;
    t = cyc;
    enable32 = 1'b0;
    push(t + 1, 0, 2'd0, 0, 0, 1, 16'd7, "en_drop_idle");
    push(t + 3, 0, 2'd0, 0, 0, 1, 16'd7, "en_drop_hold");
    repeat (3) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [20:0] act;
    int t;
    t = cyc;
    enable32 = 1'b1;
    push(t + 1, 0, 2'd1, 0, 0, 1, 16'd7, "rst_pre_flush");
    push(t + 3, 0, 2'd2, 0, 1, 1, 16'd7, "rst_pre_warmup");
    repeat (3) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
    rst32 = 1'b0;
    #1;
    checks++;
    if (obs32 !== 21'd0) begin
      errors++;
      $display("FAIL reset_in_warmup got=%h exp=%h", obs32, 21'd0);
    end
    repeat (2) tick();
    rst32 = 1'b1;
    t = cyc;
    push(t + 1,  0, 2'd1, 0, 0, 1, 16'd0, "restart_flush");
    push(t + 3,  0, 2'd2, 0, 1, 1, 16'd0, "restart_warmup");
    push(t + 22, 0, 2'd3, 0, 1, 1, 16'd0, "restart_prelock");
    push(t + 23, 0, 2'd3, 1, 1, 1, 16'd0, "restart_lock");
    repeat (23) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
    rst32 = 1'b0;
    #1;
    checks++;
    if (obs32 !== 21'd0) begin
      errors++;
      $display("FAIL reset_in_locked got=%h exp=%h", obs32, 21'd0);
    end
  endtask

  task automatic test_lock8();
    exp_t e;
    logic [20:0] act;
    int e0;
    tick();
    enable8 = 1'b1;
    rst8 = 1'b1;
    e0 = cyc + 1;
    push(e0,      1, 2'd1, 0, 0, 0, 16'd0, "w8_flush_e0");
    push(e0 + 2,  1, 2'd2, 0, 1, 0, 16'd0, "w8_warmup_e2");
    push(e0 + 10, 1, 2'd2, 0, 1, 0, 16'd0, "w8_warmup_e10");
    push(e0 + 11, 1, 2'd3, 0, 1, 0, 16'd0, "w8_search_e11");
    push(e0 + 27, 1, 2'd3, 0, 1, 0, 16'd0, "w8_prelock_e27");
    push(e0 + 28, 1, 2'd3, 1, 1, 0, 16'd0, "w8_lock_e28");
    repeat (28) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  // 300 cycles of an 8-bit count crosses 0xFF->0x00 at least once.
  task automatic test_wrap8();
    exp_t e;
    logic [20:0] act;
    int t;
    t = cyc;
    push(t + 150, 1, 2'd3, 1, 1, 0, 16'd0, "w8_wrap_mid");
    push(t + 300, 1, 2'd3, 1, 1, 0, 16'd0, "w8_wrap_end");
    repeat (300) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  // Each group: 250 inverted words -> 251 mismatches, then one match clears the bad run.
  task automatic test_err_sat();
    exp_t e;
    logic [20:0] act;
    int s;
    push(cyc + 261 * 252, 1, 2'd3, 1, 1, 0, 16'd65511, "sat_below");
    for (int g = 0; g < 262; g++) begin
      if (g == 261) begin
        s = cyc;
        push(s + 20,  1, 2'd3, 1, 1, 0, 16'hFFFA, "sat_fffa");
        push(s + 25,  1, 2'd3, 1, 1, 0, 16'hFFFF, "sat_reach");
        push(s + 252, 1, 2'd3, 1, 1, 0, 16'hFFFF, "sat_hold");
      end
      bad8 = 250;
      repeat (252) begin
        tick();
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          act = e.w8 ? obs8 : obs32;
          checks++;
          if (e.cyc != cyc || act !== e.exp) begin
            errors++;
            $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
          end
        end
      end
    end
  endtask

  task automatic test_clr_err();
    exp_t e;
    logic [20:0] act;
    int t;
    t = cyc;
    bad8 = 1;
    push(t + 1, 1, 2'd3, 1, 1, 0, 16'hFFFF, "clr_pre");
    push(t + 2, 1, 2'd3, 1, 1, 0, 16'd0, "clr_with_mismatch");
    push(t + 3, 1, 2'd3, 1, 1, 0, 16'd1, "clr_next_mismatch");
    push(t + 4, 1, 2'd3, 1, 1, 0, 16'd0, "clr_plain");
    for (int i = 0; i < 4; i++) begin
      tick();
      clr8 = (i == 0 || i == 2);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.w8 ? obs8 : obs32;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, act, e.exp);
        end
      end
    end
  endtask

  initial begin
    data32 = cnt32;
    data8  = cnt8;
    test_reset();
    test_lock();
    test_errors();
    test_wrap();
    test_bypass();
    test_enable_drop();
    test_async_reset();
    test_lock8();
    test_wrap8();
    test_err_sat();
    test_clr_err();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unconsumed %s due=%0d got=none exp=%h", sb[0].name, sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
